// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Shared types and constants for the UART command line parser:
//               handshake FSM states, ASCII classification bounds, the
//               command strings with their lengths and the command-code enum.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    // Handshake FSM: S_IDLE issues the FIFO read, S_DATA consumes the byte.
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DATA = 1'b1
    } state_t;

    // Result of matching the buffered line against the known commands.
    typedef enum logic [2:0] {
        CODE_NONE = 3'd0,
        CODE_RUN  = 3'd1,
        CODE_STOP = 3'd2,
        CODE_CLR  = 3'd3,
        CODE_ERR  = 3'd4
    } cmd_code_t;

    localparam logic [7:0] C_ASCII_CR  = 8'h0D;
    localparam logic [7:0] C_ASCII_LF  = 8'h0A;
    localparam logic [7:0] C_ASCII_BS  = 8'h08;
    localparam logic [7:0] C_PRINT_LO  = 8'h20;
    localparam logic [7:0] C_PRINT_HI  = 8'h7E;
    localparam logic [7:0] C_LOWER_A   = 8'h61;
    localparam logic [7:0] C_LOWER_Z   = 8'h7A;

    // Command strings, first character in the most significant byte.
    localparam logic [23:0] C_CMD_RUN  = "RUN";
    localparam logic [31:0] C_CMD_STOP = "STOP";
    localparam logic [23:0] C_CMD_CLR  = "CLR";
    localparam int          C_LEN_RUN  = 3;
    localparam int          C_LEN_STOP = 4;
    localparam int          C_LEN_CLR  = 3;

    // Lowercase letters map onto their uppercase counterparts; all other
    // byte values pass through unchanged.
    function automatic logic [7:0] fold_case(input logic [7:0] b);
        if ((b >= C_LOWER_A) && (b <= C_LOWER_Z)) begin
            return b - 8'h20;
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : cmd_line_buffer
// Description : MAX_LEN x 8 line storage with length counter and overflow
//               flag. Supports append, backspace and clear, and presents a
//               combinational match of the current line against the command
//               set.
// Revision    : 1.0 - initial release
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_push/i_byte - append a printable byte (overflows if full)
//               i_bs          - remove the last character, if any
//               i_clear       - empty the line and clear overflow
//               o_busy        - line holds characters or overflow is set
//               o_code        - match result (RUN/STOP/CLR/ERR)
// ============================================================================
module cmd_line_buffer
    import uart_cmd_pkg::*;
#(
    parameter int MAX_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [7:0] i_byte,
    input  logic       i_bs,
    input  logic       i_clear,
    output logic       o_busy,
    output cmd_code_t  o_code
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic [7:0]       r_buf [MAX_LEN];
    logic [LEN_W-1:0] r_len;
    logic             r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len <= '0;
            r_ovf <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                r_buf[i] <= '0;
            end
        end else if (i_clear) begin
            r_len <= '0;
            r_ovf <= 1'b0;
        end else if (i_push) begin
            if (r_len < LEN_W'(MAX_LEN)) begin
                // Write-enable decode keeps the index inside the array bounds.
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (r_len == LEN_W'(i)) begin
                        r_buf[i] <= i_byte;
                    end
                end
                r_len <= r_len + LEN_W'(1);
            end else begin
                r_ovf <= 1'b1;
            end
        end else if (i_bs && (r_len != '0)) begin
            r_len <= r_len - LEN_W'(1);
        end
    end

    assign o_busy = (r_len != '0) || r_ovf;

    // Anything that is not an exact command (or an overflowed line) is an error.
    always_comb begin
        o_code = CODE_ERR;
        if (!r_ovf) begin
            if ((r_len == LEN_W'(C_LEN_RUN)) &&
                ({r_buf[0], r_buf[1], r_buf[2]} == C_CMD_RUN)) begin
                o_code = CODE_RUN;
            end else if ((r_len == LEN_W'(C_LEN_STOP)) &&
                ({r_buf[0], r_buf[1], r_buf[2], r_buf[3]} == C_CMD_STOP)) begin
                o_code = CODE_STOP;
            end else if ((r_len == LEN_W'(C_LEN_CLR)) &&
                ({r_buf[0], r_buf[1], r_buf[2]} == C_CMD_CLR)) begin
                o_code = CODE_CLR;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_parser
// Description : Pops bytes from the UART RX FIFO, assembles an ASCII line and
//               decodes RUN / STOP / CLR into single-cycle control pulses.
//               Unknown or over-long lines produce a one-cycle error pulse.
// Revision    : 1.0 - initial release
// Ports       : clk, reset           - clock, synchronous active-high reset
//               i_fifo_data/_empty   - RX FIFO read data (valid cycle after
//                                      rd_en) and empty flag
//               o_fifo_rd_en         - RX FIFO read strobe
//               o_run/stop/clr_pulse - accepted command pulses
//               o_err_pulse          - bad or over-long line
//               o_busy               - a partial line is buffered
// Config      : CMD_CASE_FOLD_EN - fold a..z to uppercase before buffering
// ============================================================================
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int MAX_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_fifo_data,
    input  logic       i_fifo_empty,
    output logic       o_fifo_rd_en,
    output logic       o_run_pulse,
    output logic       o_stop_pulse,
    output logic       o_clr_pulse,
    output logic       o_err_pulse,
    output logic       o_busy
);

    state_t     r_state;
    state_t     w_state_next;
    logic       w_rd_en;
    logic       w_push;
    logic       w_bs;
    logic       w_eval;
    logic [7:0] w_byte;
    logic       w_busy;
    cmd_code_t  w_code;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        w_push       = 1'b0;
        w_bs         = 1'b0;
        w_eval       = 1'b0;
`ifdef CMD_CASE_FOLD_EN
        w_byte       = fold_case(i_fifo_data);
`else
        w_byte       = i_fifo_data;
`endif
        case (r_state)
            S_IDLE: begin
                w_rd_en = !i_fifo_empty;
                if (w_rd_en) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_state_next = S_IDLE;
                if ((w_byte >= C_PRINT_LO) && (w_byte <= C_PRINT_HI)) begin
                    w_push = 1'b1;
                end else if (w_byte == C_ASCII_BS) begin
                    w_bs = 1'b1;
                end else if ((w_byte == C_ASCII_CR) || (w_byte == C_ASCII_LF)) begin
                    // An empty line (e.g. the LF of a CRLF) is absorbed silently.
                    w_eval = w_busy;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // No FIFO pop while reset is held, so no byte is lost to a discarded read.
    assign o_fifo_rd_en = w_rd_en && !reset;

    cmd_line_buffer #(
        .MAX_LEN (MAX_LEN)
    ) u_line (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_byte  (w_byte),
        .i_bs    (w_bs),
        .i_clear (w_eval),
        .o_busy  (w_busy),
        .o_code  (w_code)
    );

    // The buffer always returns exactly one code, so the pulses are exclusive.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_run_pulse  <= 1'b0;
            o_stop_pulse <= 1'b0;
            o_clr_pulse  <= 1'b0;
            o_err_pulse  <= 1'b0;
        end else begin
            o_run_pulse  <= w_eval && (w_code == CODE_RUN);
            o_stop_pulse <= w_eval && (w_code == CODE_STOP);
            o_clr_pulse  <= w_eval && (w_code == CODE_CLR);
            o_err_pulse  <= w_eval && (w_code == CODE_ERR);
        end
    end

    assign o_busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_parser
// Description : Self-checking bench for uart_cmd_parser. A queue models the
//               RX FIFO; a line-level reference model predicts pulses, busy
//               and read strobes cycle by cycle. Directed vectors come from a
//               table, followed by hand-written sequences and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_parser;

    localparam int MAX_LEN = 4;
    localparam int K_NONE = 0, K_RUN = 1, K_STOP = 2, K_CLR = 3, K_ERR = 4;
`ifdef CMD_CASE_FOLD_EN
    localparam int K_FOLD = K_RUN;
`else
    localparam int K_FOLD = K_ERR;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] i_fifo_data = 8'h00;
    logic       i_fifo_empty = 1'b1;
    logic       o_fifo_rd_en, o_run_pulse, o_stop_pulse, o_clr_pulse, o_err_pulse, o_busy;

    always #5 clk = ~clk;

    uart_cmd_parser #(.MAX_LEN(MAX_LEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_fifo_data  (i_fifo_data),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_rd_en (o_fifo_rd_en),
        .o_run_pulse  (o_run_pulse),
        .o_stop_pulse (o_stop_pulse),
        .o_clr_pulse  (o_clr_pulse),
        .o_err_pulse  (o_err_pulse),
        .o_busy       (o_busy)
    );

    typedef struct {
        logic [63:0] bytes;   // first byte in [63:56]
        int          n;
        int          exp;
    } vec_t;

    int           tests = 0, fails = 0, cyc = 0;
    byte unsigned fifo_q[$];
    byte unsigned line_q[$];
    bit           m_ovf = 1'b0;
    int           exp_cyc_q[$], exp_kind_q[$];
    bit           rd_latched = 1'b0, force_empty = 1'b0, any_out = 1'b0;
    int           cnt[5];
    vec_t         vt[11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- reference model (line level) ----------------
    function automatic bit line_is(input string s);
        if (line_q.size() != s.len()) return 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            if (line_q[i] != s[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int model_byte(input byte unsigned b);
        byte unsigned c = b;
`ifdef CMD_CASE_FOLD_EN
        if (c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
`endif
        if (c >= 8'h20 && c <= 8'h7E) begin
            if (line_q.size() < MAX_LEN) line_q.push_back(c);
            else m_ovf = 1'b1;
            return K_NONE;
        end
        if (c == 8'h08) begin
            if (line_q.size() > 0) void'(line_q.pop_back());
            return K_NONE;
        end
        if (c == 8'h0D || c == 8'h0A) begin
            int k;
            if (line_q.size() == 0 && !m_ovf) return K_NONE;
            if (m_ovf)               k = K_ERR;
            else if (line_is("RUN")) k = K_RUN;
            else if (line_is("STOP")) k = K_STOP;
            else if (line_is("CLR")) k = K_CLR;
            else                     k = K_ERR;
            line_q.delete();
            m_ovf = 1'b0;
            return k;
        end
        return K_NONE;
    endfunction

    function automatic logic [3:0] kind_vec(input int k);
        case (k)
            K_RUN:   return 4'b1000;
            K_STOP:  return 4'b0100;
            K_CLR:   return 4'b0010;
            K_ERR:   return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    // One clock cycle: check outputs, service the FIFO model, check rd_en.
    task automatic step();
        logic [3:0]   got_vec, exp_vec;
        byte unsigned b;
        int           k;
        @(posedge clk);
        #1;
        cyc++;
        got_vec = {o_run_pulse, o_stop_pulse, o_clr_pulse, o_err_pulse};
        exp_vec = 4'b0000;
        if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
            exp_vec = kind_vec(exp_kind_q[0]);
            void'(exp_cyc_q.pop_front());
            void'(exp_kind_q.pop_front());
        end
        check("pulses", got_vec, exp_vec);
        check("busy", o_busy, (line_q.size() > 0) || m_ovf);
        if (o_run_pulse)  cnt[K_RUN]++;
        if (o_stop_pulse) cnt[K_STOP]++;
        if (o_clr_pulse)  cnt[K_CLR]++;
        if (o_err_pulse)  cnt[K_ERR]++;
        if (got_vec != 4'b0000 || o_busy) any_out = 1'b1;
        if (rd_latched && fifo_q.size() > 0) begin
            b = fifo_q.pop_front();
            i_fifo_data = b;
            k = model_byte(b);
            if (k != K_NONE) begin
                exp_cyc_q.push_back(cyc + 1);
                exp_kind_q.push_back(k);
            end
        end
        i_fifo_empty = force_empty || (fifo_q.size() == 0);
        #1;
        check("rd_en", o_fifo_rd_en, !i_fifo_empty && !rd_latched);
        if (o_fifo_rd_en) any_out = 1'b1;
        rd_latched = o_fifo_rd_en;
    endtask

    task automatic drain(input int extra);
        for (int g = 0; g < 4000 && (fifo_q.size() > 0 || rd_latched); g++) step();
        check("drain", fifo_q.size(), 0);
        repeat (extra) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_fifo_empty = 1'b1;
        force_empty = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        line_q.delete();
        m_ovf = 1'b0;
        exp_cyc_q.delete();
        exp_kind_q.delete();
        rd_latched = 1'b0;
    endtask

    task automatic clear_counts();
        foreach (cnt[i]) cnt[i] = 0;
    endtask

    function automatic logic [31:0] exp_counts(input int k);
        logic [31:0] e = 32'h0;
        if (k != K_NONE) e[8*(4-k) +: 8] = 8'd1;
        return e;
    endfunction

    function automatic logic [31:0] got_counts();
        return {cnt[K_RUN][7:0], cnt[K_STOP][7:0], cnt[K_CLR][7:0], cnt[K_ERR][7:0]};
    endfunction

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) fifo_q.push_back(s[i]);
    endtask

    initial begin
        byte unsigned alpha[16];
        alpha = '{8'h52, 8'h55, 8'h4E, 8'h53, 8'h54, 8'h4F, 8'h50, 8'h43,
                  8'h4C, 8'h58, 8'h72, 8'h6E, 8'h08, 8'h0D, 8'h0A, 8'h1B};

        vt[0]  = '{64'h52554E0D_00000000, 4, K_RUN};   // RUN\r
        vt[1]  = '{64'h53544F50_0D0A0000, 6, K_STOP};  // STOP\r\n
        vt[2]  = '{64'h434C520A_00000000, 4, K_CLR};   // CLR\n
        vt[3]  = '{64'h52554E58_0D000000, 5, K_ERR};   // RUNX\r
        vt[4]  = '{64'h53544F50_500D0000, 6, K_ERR};   // STOPP\r overflow
        vt[5]  = '{64'h52555808_4E0D0000, 6, K_RUN};   // RUX BS N \r
        vt[6]  = '{64'h72756E0D_00000000, 4, K_FOLD};  // run\r
        vt[7]  = '{64'h00431B4C_FF520D00, 7, K_CLR};   // junk bytes inside CLR
        vt[8]  = '{64'h0D0A0000_00000000, 2, K_NONE};  // empty line
        vt[9]  = '{64'h52550D00_00000000, 3, K_ERR};   // RU\r
        vt[10] = '{64'h52554E20_0D000000, 5, K_ERR};   // "RUN "\r

        do_reset();
        #1;
        check("reset_pulses", {o_run_pulse, o_stop_pulse, o_clr_pulse, o_err_pulse}, 4'b0000);
        check("reset_busy", o_busy, 1'b0);
        check("reset_rd_en", o_fifo_rd_en, 1'b0);

        // Table-driven directed vectors
        for (int i = 0; i < 11; i++) begin
            clear_counts();
            for (int j = 0; j < vt[i].n; j++) fifo_q.push_back(vt[i].bytes[63-8*j -: 8]);
            drain(3);
            check("vec_counts", got_counts(), exp_counts(vt[i].exp));
            check("vec_busy_end", o_busy, 1'b0);
        end

        // Empty FIFO for 100 cycles: nothing may move
        any_out = 1'b0;
        force_empty = 1'b1;
        repeat (100) step();
        force_empty = 1'b0;
        check("idle_quiet", any_out, 1'b0);

        // Partial line discarded by reset
        clear_counts();
        push_str("CL");
        drain(1);
        check("busy_partial", o_busy, 1'b1);
        do_reset();
        #1;
        check("busy_after_reset", o_busy, 1'b0);
        push_str("R\r");
        drain(3);
        check("post_reset_R", got_counts(), exp_counts(K_ERR));

        // Randomized traffic against the reference model
        for (int r = 0; r < 500; r++) begin
            case ($urandom_range(0, 11))
                0:       push_str("RUN\r");
                1:       push_str("STOP\n");
                2:       push_str("CLR\r\n");
                3:       push_str("run\r");
                4:       fifo_q.push_back(8'($urandom_range(0, 255)));
                default: fifo_q.push_back(alpha[$urandom_range(0, 15)]);
            endcase
        end
        for (int g = 0; g < 20000 && (fifo_q.size() > 0 || rd_latched); g++) begin
            force_empty = ($urandom_range(0, 9) == 0);
            step();
        end
        force_empty = 1'b0;
        drain(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Line-oriented command parser between the UART receive FIFO and the stopwatch control FSM. Pops bytes from the RX FIFO with a proper empty/rd_en handshake, assembles them into a short ASCII line, and on a line terminator decodes the commands `RUN`, `STOP` and `CLR` into single-cycle control pulses. Unrecognised or over-long lines raise a one-cycle error pulse; the counter datapath is never touched directly.

## Interface
Parameters:
- MAX_LEN, 4: maximum command characters buffered, excluding the terminator; legal range 4..8.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_fifo_data  in  8  RX FIFO dout; valid the cycle after rd_en
- i_fifo_empty  in  1  RX FIFO empty flag
- o_fifo_rd_en  out  1  RX FIFO read strobe
- o_run_pulse  out  1  one-cycle pulse: line `RUN` accepted
- o_stop_pulse  out  1  one-cycle pulse: line `STOP` accepted
- o_clr_pulse  out  1  one-cycle pulse: line `CLR` accepted
- o_err_pulse  out  1  one-cycle pulse: bad or over-long line
- o_busy  out  1  high while the line buffer holds characters (len > 0 or overflow set)

## Operation
- States: S_IDLE, S_DATA.
- S_IDLE: o_fifo_rd_en = !i_fifo_empty (combinational). If rd_en, go to S_DATA; otherwise stay.
- S_DATA: i_fifo_data is valid; classify the byte; always return to S_IDLE.
- Printable byte, 0x20..0x7E: append if len < MAX_LEN; otherwise set the overflow flag and discard the byte.
- 0x08 (backspace): len decrements if len > 0; overflow is unaffected.
- CR 0x0D or LF 0x0A: if len == 0 and overflow is clear, ignore it (this absorbs CRLF and empty lines). Otherwise evaluate the line, then clear len and overflow.
- Evaluation: an exact match of buffer[0..len-1] against `RUN`, `STOP` or `CLR` raises the matching pulse. Any other content, or overflow set, raises o_err_pulse.
- Any other byte (control characters other than those above, or 0x7F..0xFF) is dropped silently.
- Pulses are mutually exclusive; at most one is high in any cycle.

## Timing
- Reset: state S_IDLE, len 0, overflow 0. All pulses, o_busy and the buffer are 0. o_fifo_rd_en follows i_fifo_empty from the first cycle after reset.
- Byte read: rd_en in cycle N, byte captured in N+1. A terminator captured in N+1 produces its pulse, registered, in N+2.
- Throughput: one byte per 2 cycles. The next rd_en can issue in N+2, concurrently with the pulse.
- A reset asserted while in S_DATA discards the in-flight byte and the partial line.
- A pulse is exactly 1 cycle wide; back-to-back terminators yield pulses at least 2 cycles apart.

## Configuration
- CMD_CASE_FOLD_EN defined: bytes 0x61..0x7A are converted to uppercase before being buffered, so `run`, `Stop` and `cLr` are all accepted.
- Not defined: bytes are stored verbatim, matching is case-sensitive, and lowercase commands raise o_err_pulse.

## Structure
- Shared package `uart_cmd_pkg`:
  - state enum.
  - ASCII constants: CR, LF, BS, printable low/high bounds.
  - command string constants and their lengths.
  - command-code enum: NONE, RUN, STOP, CLR, ERR.
- Sub-module `cmd_line_buffer`:
  - holds the MAX_LEN x 8 storage, len and overflow.
  - handles append, backspace and clear.
  - exposes a combinational command-code match output.
- The top-level parser owns the handshake FSM and the output pulse registers.

## Test plan
- FIFO presents 'R','U','N',0x0D with empty low -> o_fifo_rd_en toggles on alternate cycles; o_run_pulse high for exactly 1 cycle, 2 cycles after the CR rd_en; other pulses stay low.
- "STOP\r\n" then "CLR\n" -> exactly one o_stop_pulse and one o_clr_pulse; the LF after CR produces nothing.
- "RUNX\r" -> o_err_pulse. "STOPP\r" with MAX_LEN=4 -> overflow, o_err_pulse, and len returns to 0.
- "RUX", 0x08, 'N', 0x0D -> o_run_pulse. "run\r" -> o_run_pulse with CMD_CASE_FOLD_EN defined, o_err_pulse without it.
- i_fifo_empty held high for 100 cycles -> rd_en never asserts and all outputs stay 0. Reset asserted after "CL" -> o_busy drops to 0; a following "R\r" gives o_err_pulse, not a clear.
- Bytes 0x00, 0x1B, 0xFF inside "C",0x1B,"LR\r" -> dropped silently; o_clr_pulse.
